// File: rtl/vga_pixel_stream_out.sv
// VGA raster generator at the display end of the drawing chain: publishes the pixel
// coordinate, then realigns sync/blank with the returned colour and expands RRRGGGBB to 8/8/8.
module vga_pixel_stream_out #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter int   PIPE_LAT = 2,
  parameter logic SYNC_ACT = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pixEn,
  input  logic [7:0]  RGBIn,
  output logic [10:0] pixelX,
  output logic [10:0] pixelY,
  output logic        startOfFrame,
  output logic        hsync,
  output logic        vsync,
  output logic        blankN,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue
);

  localparam logic [10:0] H_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] V_LAST  = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [10:0] H_ACT   = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT   = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END  = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END  = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [2:0]  IDLE_P  = {1'b0, ~SYNC_ACT, ~SYNC_ACT};

  // 3-bit channels replicate their MSBs to reach full scale (111 -> FF)
  function automatic logic [7:0] expand3(input logic [2:0] c);
    return {c, c, c[2:1]};
  endfunction

  function automatic logic [7:0] expand2(input logic [1:0] c);
    return {c, c, c, c};
  endfunction

  logic [10:0] hCnt;
  logic [10:0] vCnt;
  logic        hWrap;
  logic        vWrap;
  logic [2:0]  raw_p0;   // {active, hsync, vsync} of the coordinate now on pixelX/pixelY
  logic [2:0]  dly;      // same bits for the coordinate whose colour is on RGBIn

  assign hWrap  = (hCnt == H_LAST);
  assign vWrap  = (vCnt == V_LAST);
  assign pixelX = hCnt;
  assign pixelY = vCnt;

  // ---- stage 0: raster counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hCnt         <= '0;
      vCnt         <= '0;
      startOfFrame <= 1'b0;
    end else if (pixEn) begin
      if (hWrap) begin
        hCnt <= '0;
        if (vWrap) vCnt <= '0;
        else       vCnt <= vCnt + 11'd1;
      end else begin
        hCnt <= hCnt + 11'd1;
      end
      startOfFrame <= hWrap && vWrap;
    end
  end

  always_comb begin
    raw_p0    = IDLE_P;
    raw_p0[2] = (hCnt < H_ACT) && (vCnt < V_ACT);
    if ((hCnt >= HS_BEG) && (hCnt < HS_END)) raw_p0[1] = SYNC_ACT;
    if ((vCnt >= VS_BEG) && (vCnt < VS_END)) raw_p0[0] = SYNC_ACT;
  end

  // ---- stages 1..PIPE_LAT-1: timing delay line; the output register is the last stage
  generate
    if (PIPE_LAT <= 1) begin : g_nodelay
      assign dly = raw_p0;
    end else begin : g_delay
      logic [2:0] sr_p1 [PIPE_LAT-1];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < PIPE_LAT-1; i++) sr_p1[i] <= IDLE_P;
        end else if (pixEn) begin
          sr_p1[0] <= raw_p0;
          for (int i = 1; i < PIPE_LAT-1; i++) sr_p1[i] <= sr_p1[i-1];
        end
      end

      assign dly = sr_p1[PIPE_LAT-2];
    end
  endgenerate

  // ---- final stage: colour capture aligned with delayed sync/blank
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync  <= ~SYNC_ACT;
      vsync  <= ~SYNC_ACT;
      blankN <= 1'b0;
      red    <= '0;
      green  <= '0;
      blue   <= '0;
    end else if (pixEn) begin
      hsync  <= dly[1];
      vsync  <= dly[0];
      blankN <= dly[2];
      if (dly[2]) begin
        red   <= expand3(RGBIn[7:5]);
        green <= expand3(RGBIn[4:2]);
        blue  <= expand2(RGBIn[1:0]);
      end else begin
        red   <= '0;
        green <= '0;
        blue  <= '0;
      end
    end
  end

endmodule

// File: doc/vga_pixel_stream_out.md
Name: vga_pixel_stream_out

Overview:
Display-side end of the object drawing chain. It generates the VGA raster: pixel counters, sync and blanking. It publishes the current pixel coordinate to every drawing unit and accepts the prioritised 8-bit RGB returned by the objects mux a fixed number of pixel ticks later. That colour is aligned with delayed sync/blank, expanded to 8/8/8 and driven to the VGA DAC.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
PIPE_LAT, 2, pixel ticks from pixelX/pixelY to matching RGBIn (range 1..4)
SYNC_ACT, 0, asserted level of hsync/vsync

Ports:
clk  in  1  system clock
reset  in  1  reset; one clock; reset is asynchronous and active-high
pixEn  in  1  pixel tick enable; all state advances only when high
RGBIn  in  8  colour from objects mux, RRRGGGBB
pixelX  out  11  current horizontal count (0..HTOTAL-1)
pixelY  out  11  current vertical count (0..VTOTAL-1)
startOfFrame  out  1  one-tick pulse when the raster wraps to (0,0)
hsync  out  1  horizontal sync, delayed PIPE_LAT ticks
vsync  out  1  vertical sync, delayed PIPE_LAT ticks
blankN  out  1  high when the delayed pixel is in the active area
red  out  8  expanded red
green  out  8  expanded green
blue  out  8  expanded blue

Behaviour:
- HTOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); VTOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- hCnt increments on each pixEn tick. At HTOTAL-1 it wraps to 0 and vCnt increments. vCnt wraps to 0 at VTOTAL-1 when hCnt also wraps.
- pixelX = hCnt and pixelY = vCnt, both registered.
- Raw active = (hCnt < H_ACTIVE) && (vCnt < V_ACTIVE).
- Raw hsync = SYNC_ACT when hCnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); otherwise !SYNC_ACT. Raw vsync uses the same rule on vCnt with the V_* parameters.
- Raw active, hsync and vsync pass through a PIPE_LAT-deep shift register that advances only on pixEn.
- On a pixEn tick where the delayed active bit is 1:
  - red = {R,R,R[2:1]}, green = {G,G,G[2:1]}, blue = {B,B,B,B}, sampled from RGBIn that tick.
  - blankN = 1.
- On a pixEn tick where the delayed active bit is 0: red, green and blue are forced to 0 and blankN = 0, whatever RGBIn is.
- startOfFrame = 1 for exactly one pixEn tick, coincident with pixelX=0 and pixelY=0 appearing after a wrap from (HTOTAL-1, VTOTAL-1). It deasserts on the next pixEn tick. It is not asserted on exit from reset.
- pixEn low: counters, pipeline, colours, syncs and startOfFrame all hold their values. A held startOfFrame stays high until the next tick.
- Reset value of every output:
  - pixelX = 0, pixelY = 0, startOfFrame = 0.
  - hsync = vsync = !SYNC_ACT.
  - blankN = 0, red = green = blue = 0.
  - Pipeline cleared to inactive/deasserted.
- Reset mid-frame takes effect immediately (asynchronous). After release, counting restarts at (0,0) on the first pixEn tick, with no partial-frame recovery.
- Simultaneous horizontal and vertical wrap: both counters reach 0 in the same tick, and the startOfFrame rule above applies.
- Latency: RGBIn must correspond to the coordinate issued PIPE_LAT ticks earlier. Sync and blank outputs follow raw raster timing by exactly PIPE_LAT ticks.

Test Plan:
- Reset then pixEn=1 every clk for 800 ticks -> pixelX counts 0..799 and wraps to 0, pixelY goes 0->1. Raw hsync is active for hCnt 656..751, appearing on the hsync pin 2 ticks later (PIPE_LAT=2).
- Run a full frame of 420000 ticks -> startOfFrame pulses once, at the (799,524)->(0,0) wrap. vsync is low for lines 490..491 only.
- Drive RGBIn=8'hE0 while delayed active -> red=8'hFF, green=0, blue=0, blankN=1. Drive RGBIn=8'h03 -> blue=8'hFF. Drive RGBIn=8'h92 (100_100_10) -> red=8'h92, green=8'h92, blue=8'hAA.
- Drive RGBIn=8'hFF during hCnt 640..799 (delayed) -> red/green/blue=0, blankN=0.
- Toggle pixEn 1-of-2 clocks -> all outputs hold on idle clocks, and a line takes 1600 clk. startOfFrame is held high for 2 clk.
- Assert reset at pixelX=300, pixelY=200 -> all outputs take reset values the same cycle. After release, the raster restarts at (0,0) and startOfFrame stays 0 until the next full wrap.
